// File: rtl/ir_transmitter.sv
// ir_transmitter: NEC infrared frame generator.
// Sends a 16-unit lead mark, an 8-unit lead space, 32 data bits (LSB first) and
// a 1-unit stop mark. The frame word is {~command, command, ~address, address}.
// Each data bit is a 1-unit mark followed by a 1-unit space (bit 0) or a
// 3-unit space (bit 1).
//
// Ports:
//   clk      - single clock, rising edge
//   reset    - synchronous, active-high
//   send     - frame request, sampled only in IDLE
//   address  - NEC address, captured together with send
//   command  - NEC command, captured together with send
//   ir_out   - envelope gated by the carrier, drives the IR LED
//   ir_env   - unmodulated envelope (1 = mark)
//   busy     - high in every state except IDLE
//   done     - one-cycle pulse in FINISH
//
// state      | meaning
// IDLE       | waiting for send
// LEAD_MARK  | 16-unit leader burst
// LEAD_SPACE | 8-unit leader gap
// BIT_MARK   | 1-unit burst that opens every data bit
// BIT_SPACE  | 1-unit (bit 0) or 3-unit (bit 1) gap
// STOP_MARK  | 1-unit trailing burst
// FINISH     | single cycle, done pulse
module ir_transmitter #(
  parameter int UNIT_CYCLES  = 28125,
  parameter int CARRIER_HALF = 658
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] address,
  input  logic [7:0] command,
  output logic       ir_out,
  output logic       ir_env,
  output logic       busy,
  output logic       done
);

  // Guard against $clog2(1) = 0 so every counter is at least one bit wide.
  localparam int UW = (UNIT_CYCLES  > 1) ? $clog2(UNIT_CYCLES)  : 1;
  localparam int CW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
  localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT_CYCLES - 1);
  localparam logic [CW-1:0] CAR_LAST  = CW'(CARRIER_HALF - 1);

  typedef enum logic [2:0] {
    IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, FINISH
  } state_t;

  state_t        state, state_next;
  logic [UW-1:0] unit_cnt;
  logic [4:0]    unit_num;
  logic [4:0]    unit_len;
  logic [5:0]    bit_idx;
  logic [31:0]   frame;
  logic [CW-1:0] carrier_cnt;
  logic          carrier_phase;
  logic          unit_end;
  logic          state_end;
  logic          next_is_mark;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    unit_len = 5'd1;
    case (state)
      LEAD_MARK:  unit_len = 5'd16;
      LEAD_SPACE: unit_len = 5'd8;
      BIT_SPACE:  unit_len = frame[bit_idx[4:0]] ? 5'd3 : 5'd1;
      default:    unit_len = 5'd1;
    endcase
    unit_end  = (unit_cnt == UNIT_LAST);
    state_end = unit_end && (unit_num == unit_len - 5'd1);

    state_next = state;
    ir_env     = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (send) state_next = LEAD_MARK;
      end
      LEAD_MARK: begin
        ir_env = 1'b1;
        if (state_end) state_next = LEAD_SPACE;
      end
      LEAD_SPACE: begin
        if (state_end) state_next = BIT_MARK;
      end
      BIT_MARK: begin
        ir_env = 1'b1;
        if (state_end) state_next = BIT_SPACE;
      end
      BIT_SPACE: begin
        if (state_end) state_next = (bit_idx == 6'd31) ? STOP_MARK : BIT_MARK;
      end
      STOP_MARK: begin
        ir_env = 1'b1;
        if (state_end) state_next = FINISH;
      end
      FINISH: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    next_is_mark = (state_next == LEAD_MARK) || (state_next == BIT_MARK) ||
                   (state_next == STOP_MARK);
    ir_out = ir_env & carrier_phase;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      unit_cnt      <= '0;
      unit_num      <= '0;
      bit_idx       <= '0;
      frame         <= '0;
      carrier_cnt   <= '0;
      carrier_phase <= 1'b0;
    end else begin
      // Unit timing restarts on every state change.
      if (state_next != state) begin
        unit_cnt <= '0;
        unit_num <= '0;
      end else if (unit_end) begin
        unit_cnt <= '0;
        unit_num <= unit_num + 5'd1;
      end else begin
        unit_cnt <= unit_cnt + 1'b1;
      end

      if (state == IDLE && send) begin
        frame   <= {~command, command, ~address, address};
        bit_idx <= '0;
      end else if (state == BIT_SPACE && state_end && bit_idx != 6'd31) begin
        bit_idx <= bit_idx + 6'd1;
      end

      // Every mark begins with the carrier high; outside marks it is parked low.
      if (next_is_mark && state_next != state) begin
        carrier_cnt   <= '0;
        carrier_phase <= 1'b1;
      end else if (next_is_mark) begin
        if (carrier_cnt == CAR_LAST) begin
          carrier_cnt   <= '0;
          carrier_phase <= ~carrier_phase;
        end else begin
          carrier_cnt <= carrier_cnt + 1'b1;
        end
      end else begin
        carrier_cnt   <= '0;
        carrier_phase <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ir_transmitter.sv
// Bench for ir_transmitter with UNIT_CYCLES=4, CARRIER_HALF=1.
// A cycle-by-cycle expected waveform is built from the NEC frame rules, and the
// recorded envelope is decoded back into a 32-bit word like a receiver would.
module tb_ir_transmitter;
  localparam int U  = 4;
  localparam int CH = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       send = 1'b0;
  logic [7:0] address = 8'h00;
  logic [7:0] command = 8'h00;
  logic       ir_out, ir_env, busy, done;

  int checks = 0;
  int errors = 0;
  bit env_seen[$];

  ir_transmitter #(.UNIT_CYCLES(U), .CARRIER_HALF(CH)) dut (
    .clk(clk), .reset(reset), .send(send), .address(address), .command(command),
    .ir_out(ir_out), .ir_env(ir_env), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Receiver-style decode of the recorded envelope: run lengths to bits.
  function automatic logic [31:0] decode_env();
    int lvl_q[$];
    int len_q[$];
    logic [31:0] w;
    w = '0;
    foreach (env_seen[i]) begin
      if (lvl_q.size() == 0 || lvl_q[lvl_q.size()-1] != int'(env_seen[i])) begin
        lvl_q.push_back(int'(env_seen[i]));
        len_q.push_back(1);
      end else begin
        len_q[len_q.size()-1] = len_q[len_q.size()-1] + 1;
      end
    end
    if (lvl_q.size() != 67 || lvl_q[0] != 1 || len_q[0] != 16*U ||
        len_q[1] != 8*U || len_q[66] != U) return 'x;
    for (int b = 0; b < 32; b++) begin
      if (len_q[2+2*b] != U) return 'x;
      if (len_q[3+2*b] == U)        w[b] = 1'b0;
      else if (len_q[3+2*b] == 3*U) w[b] = 1'b1;
      else return 'x;
    end
    return w;
  endfunction

  // Caller is at a negedge with send=1 and address/command set.
  // interfere: pulse send with other data at cycle 100 of the frame.
  // hold: leave send high throughout; new_a/new_c are applied at cycle 11.
  task automatic check_frame(input logic [7:0] a, input logic [7:0] c,
                             input bit interfere, input bit hold,
                             input logic [7:0] new_a, input logic [7:0] new_c);
    logic [31:0] fr;
    bit exp_env[$];
    bit exp_out[$];
    int n_units;
    logic [31:0] dec;
    fr = {~c, c, ~a, a};
    for (int j = 0; j < 16*U; j++) begin exp_env.push_back(1); exp_out.push_back(((j / CH) % 2) == 0); end
    for (int j = 0; j < 8*U; j++) begin exp_env.push_back(0); exp_out.push_back(0); end
    for (int b = 0; b < 32; b++) begin
      for (int j = 0; j < U; j++) begin exp_env.push_back(1); exp_out.push_back(((j / CH) % 2) == 0); end
      for (int j = 0; j < (fr[b] ? 3*U : U); j++) begin exp_env.push_back(0); exp_out.push_back(0); end
    end
    for (int j = 0; j < U; j++) begin exp_env.push_back(1); exp_out.push_back(((j / CH) % 2) == 0); end
    n_units = exp_env.size() / U;
    env_seen.delete();

    @(posedge clk);
    @(negedge clk);
    if (!hold) send = 1'b0;
    for (int i = 0; i < exp_env.size(); i++) begin
      checks++;
      if (ir_env !== exp_env[i]) begin
        errors++; $display("FAIL ir_env cycle %0d: got %b want %b", i+1, ir_env, exp_env[i]);
      end
      checks++;
      if (ir_out !== exp_out[i]) begin
        errors++; $display("FAIL ir_out cycle %0d: got %b want %b", i+1, ir_out, exp_out[i]);
      end
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++; $display("FAIL busy/done cycle %0d: got %b/%b want 1/0", i+1, busy, done);
      end
      env_seen.push_back(ir_env === 1'b1);
      if (interfere && i == 99) begin send = 1'b1; address = ~a; command = ~c; end
      if (interfere && i == 100 && !hold) send = 1'b0;
      if (hold && i == 10) begin address = new_a; command = new_c; end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || ir_env !== 1'b0 || ir_out !== 1'b0) begin
      errors++;
      $display("FAIL finish cycle %0d (N=%0d): got done=%b busy=%b env=%b out=%b want 1 1 0 0",
               n_units*U+1, n_units, done, busy, ir_env, ir_out);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || ir_out !== 1'b0) begin
      errors++; $display("FAIL idle after finish: got busy=%b done=%b out=%b want 0 0 0", busy, done, ir_out);
    end
    dec = decode_env();
    checks++;
    if (dec !== fr) begin
      errors++; $display("FAIL decoded frame: got %h want %h", dec, fr);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    send  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({ir_out, ir_env, busy, done} !== 4'b0000) begin
        errors++; $display("FAIL reset state: got out/env/busy/done=%b want 0000", {ir_out, ir_env, busy, done});
      end
    end
    reset = 1'b0;
    send  = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL idle after reset: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_zero_frame();
    address = 8'h00; command = 8'h00; send = 1'b1;
    check_frame(8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
  endtask

  task automatic test_known_frame();
    logic [31:0] dec;
    address = 8'hA5; command = 8'h3C; send = 1'b1;
    check_frame(8'hA5, 8'h3C, 0, 0, 8'h00, 8'h00);
    dec = decode_env();
    checks++;
    if (dec !== 32'hC33C5AA5) begin
      errors++; $display("FAIL known frame decode: got %h want c33c5aa5", dec);
    end
  endtask

  task automatic test_send_ignored();
    logic [7:0] a, c;
    a = 8'($urandom); c = 8'($urandom);
    address = a; command = c; send = 1'b1;
    check_frame(a, c, 1, 0, 8'h00, 8'h00);
  endtask

  task automatic test_random();
    logic [7:0] a, c;
    for (int k = 0; k < 3; k++) begin
      a = 8'($urandom); c = 8'($urandom);
      address = a; command = c; send = 1'b1;
      check_frame(a, c, 0, 0, 8'h00, 8'h00);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] a, c;
    address = 8'($urandom); command = 8'($urandom); send = 1'b1;
    @(posedge clk);
    @(negedge clk);
    send = 1'b0;
    repeat (199) @(negedge clk);
    reset = 1'b1;
    send  = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    send  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({ir_out, ir_env, busy, done} !== 4'b0000) begin
        errors++; $display("FAIL after mid-frame reset +%0d: got out/env/busy/done=%b want 0000", i, {ir_out, ir_env, busy, done});
      end
      @(negedge clk);
    end
    a = 8'($urandom); c = 8'($urandom);
    address = a; command = c; send = 1'b1;
    check_frame(a, c, 0, 0, 8'h00, 8'h00);
  endtask

  task automatic test_reset_release();
    logic [7:0] a, c;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    a = 8'($urandom); c = 8'($urandom);
    address = a; command = c; send = 1'b1;
    check_frame(a, c, 0, 0, 8'h00, 8'h00);
  endtask

  task automatic test_back_to_back();
    logic [7:0] a1, c1, a2, c2;
    a1 = 8'($urandom); c1 = 8'($urandom);
    a2 = ~a1; c2 = 8'($urandom);
    address = a1; command = c1; send = 1'b1;
    check_frame(a1, c1, 0, 1, a2, c2);
    check_frame(a2, c2, 0, 0, 8'h00, 8'h00);
  endtask

  initial begin
    test_reset();
    test_zero_frame();
    test_known_frame();
    test_send_ignored();
    test_random();
    test_reset_mid_frame();
    test_reset_release();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ir_transmitter.md
IR_TRANSMITTER -- requirements
Module: ir_transmitter

Interface
REQ-001 SHALL have parameter UNIT_CYCLES, default 28125: clk cycles per NEC time unit (562.5 us at 50 MHz); legal values are 2 or more.
REQ-002 SHALL have parameter CARRIER_HALF, default 658: clk cycles per carrier half-period (about 38 kHz at 50 MHz); legal values are 1 or more.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port send, input, 1 bit: frame request, sampled only in IDLE.
REQ-006 SHALL have port address, input, 8 bits: NEC address, captured with send.
REQ-007 SHALL have port command, input, 8 bits: NEC command, captured with send.
REQ-008 SHALL have port ir_out, output, 1 bit: carrier-modulated drive to the IR LED.
REQ-009 SHALL have port ir_env, output, 1 bit: unmodulated envelope (1 = mark), for loopback into the IR receive state machine.
REQ-010 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when a frame completes.

Function
REQ-012 SHALL implement states IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK and FINISH.
REQ-013 SHALL move IDLE to LEAD_MARK on an edge where send=1, and on that same edge latch frame = {~command, command, ~address, address}.
REQ-014 SHALL ignore send in every state other than IDLE; no queuing, no frame corruption.
REQ-015 SHALL set the state durations in units as: LEAD_MARK 16; LEAD_SPACE 8; BIT_MARK 1; BIT_SPACE 1 for a 0 bit, 3 for a 1 bit; STOP_MARK 1; FINISH exactly 1 clk cycle.
REQ-016 SHALL transmit the 32 frame bits LSB first (bit 0 = address[0]) through BIT_MARK/BIT_SPACE pairs; after the bit-31 space, go to STOP_MARK.
REQ-017 SHALL return from FINISH to IDLE unconditionally.
REQ-018 SHALL use a unit counter that counts 0..UNIT_CYCLES-1 and wraps; a per-state unit count advances the state on the last cycle of its final unit.
REQ-019 SHALL use a 6-bit bit index, reset to 0 on entering LEAD_MARK; BIT_SPACE exits to STOP_MARK when index = 31, otherwise increments the index.
REQ-020 SHALL drive ir_env = 1 in LEAD_MARK, BIT_MARK and STOP_MARK, and 0 otherwise.
REQ-021 SHALL drive ir_out = ir_env AND carrier_phase, where carrier_phase is forced to 1 and the carrier counter cleared on every mark entry, and carrier_phase toggles every CARRIER_HALF cycles within a mark.
REQ-022 SHALL keep ir_out at 0 in every space, IDLE and FINISH; no carrier leaks outside marks.
REQ-023 SHALL drive done = 1 only in FINISH.
REQ-024 SHALL keep busy and done mutually consistent: done=1 implies busy=1.
REQ-025 SHALL give frame timing such that send sampled at edge k puts ir_env=1 from cycle k+1; FINISH occupies cycle k+1+N*UNIT_CYCLES, where N = 24 + 2*zeros + 4*ones + 1.
REQ-026 SHALL keep address and command changes after capture from affecting the frame in flight.
REQ-027 SHALL, when send is held high continuously, start back-to-back frames separated by exactly one IDLE cycle.
REQ-028 SHALL size counter widths with $clog2 of the parameters; no truncation at default or minimum values.

Reset
REQ-029 SHALL, with reset=1 at an edge, force state IDLE, all counters and the bit index to 0, carrier_phase=0, and ir_out=ir_env=busy=done=0.
REQ-030 SHALL give reset priority over send on the same edge; a mid-frame reset aborts the frame with no done pulse, and ir_out is 0 from the next cycle.
REQ-031 SHALL accept a new frame request on the first edge after reset deasserts.

Verification (UNIT_CYCLES=4, CARRIER_HALF=1)
REQ-032 SHALL cover: address=0x00, command=0x00, single-cycle send at edge 0 -> ir_env high cycles 1-64, low 65-96, N=121, done high only in cycle 485, busy low at cycle 486.
REQ-033 SHALL cover: address=0xA5, command=0x3C -> envelope decodes LSB first to 0xC33C5AA5, and the IR receive state machine fed ir_env reaches END with no ERROR.
REQ-034 SHALL cover: checking ir_out inside the lead mark -> pattern 1,0,1,0,... starting high at cycle 1, and 0 throughout every space.
REQ-035 SHALL cover: send pulsed again at cycle 100 with different data -> ignored; the frame is unchanged and exactly one done pulse occurs.
REQ-036 SHALL cover: reset asserted at cycle 200 -> from cycle 201, ir_out=ir_env=busy=0 and no done; a send two cycles after reset release starts a full correct frame.
REQ-037 SHALL cover: send held high for 2 frames -> the second LEAD_MARK begins exactly 2 cycles after the first done.
